pcs_rx_descrambler_lock: RTL and testbench

Receive-side 10GBASE-R style PCS block that descrambles the 64b/66b payload with the self-synchronising polynomial x^58 + x^39 + 1, at a configurable datapath width.
It also checks each 2-bit sync header and runs the block-lock state machine, which requests gearbox slips while hunting.
It sits between the RX gearbox and the 64b/66b decoder.
Over the fixed 64-bit descrambler it adds width parametrisation, bypass mode, sync-header lock/loss tracking and error counting.

---
 rtl/pcs_rx_descrambler_lock.sv | 126 ++++++++++++
 tb/tb_pcs_rx_descrambler_lock.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_descrambler_lock.sv
// 64b/66b receive descrambler (x^58 + x^39 + 1) with sync-header block-lock tracking.
// Sits between the RX gearbox and the 64b/66b decoder; requests gearbox slips while hunting.
module pcs_rx_descrambler_lock #(
    parameter int unsigned PCS_DATA_WIDTH = 64,
    parameter int unsigned LOCK_CNT       = 64,
    parameter int unsigned WINDOW         = 64,
    parameter int unsigned BAD_LIMIT      = 16,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PCS_DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                in_header,
    input  logic                      in_data_valid,
    input  logic                      bypass,
    output logic [PCS_DATA_WIDTH-1:0] out_data,
    output logic [1:0]                out_header,
    output logic                      out_data_valid,
    output logic                      block_lock,
    output logic                      slip,
    output logic [ERR_CNT_W-1:0]      bad_hdr_cnt
);

    localparam int unsigned W      = PCS_DATA_WIDTH;
    localparam int unsigned SW     = 58;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_LIMIT + 1);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e            state_q;
    logic [SW-1:0]     s_q;
    logic              phase_q;
    logic [GOOD_W-1:0] good_cnt_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [BAD_W-1:0]  bad_cnt_q;

    logic [W+SW-1:0]   x_ext;
    logic [W-1:0]      descr;
    logic              hdr_slot;
    logic              hdr_good;
    logic              hdr_chk;

    // x_ext[SW + k] is received bit k of this beat; negative k falls into the saved state.
    assign x_ext    = {in_data, s_q};
    assign descr    = in_data ^ x_ext[W+SW-40:SW-39] ^ x_ext[W-1:0];

    // At 32 bits two beats make one block, so only every other valid beat has a header.
    assign hdr_slot = (W == 64) ? 1'b1 : ~phase_q;
    assign hdr_good = in_header[0] ^ in_header[1];
    assign hdr_chk  = in_data_valid & hdr_slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q            <= '0;
            phase_q        <= 1'b0;
            out_data       <= '0;
            out_header     <= '0;
            out_data_valid <= 1'b0;
            bad_hdr_cnt    <= '0;
        end else begin
            if (in_data_valid) begin
                s_q      <= x_ext[W+SW-1:W];
                out_data <= bypass ? in_data : descr;
                phase_q  <= ~phase_q;
            end
            out_header     <= in_header;
            out_data_valid <= in_data_valid;
            if (hdr_chk && !hdr_good && (bad_hdr_cnt != '1)) begin
                bad_hdr_cnt <= bad_hdr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StHunt;
            good_cnt_q <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            block_lock <= 1'b0;
            slip       <= 1'b0;
        end else begin
            slip <= 1'b0;
            if (hdr_chk) begin
                unique case (state_q)
                    StHunt: begin
                        if (hdr_good) begin
                            if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_q    <= StLocked;
                                block_lock <= 1'b1;
                                good_cnt_q <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + 1'b1;
                            end
                        end else begin
                            good_cnt_q <= '0;
                            slip       <= 1'b1;
                        end
                    end
                    StLocked: begin
                        // Hitting the bad limit takes priority over closing the window.
                        if (!hdr_good && (bad_cnt_q == BAD_W'(BAD_LIMIT - 1))) begin
                            state_q    <= StHunt;
                            block_lock <= 1'b0;
                            slip       <= 1'b1;
                            win_cnt_q  <= '0;
                            bad_cnt_q  <= '0;
                        end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                            win_cnt_q <= '0;
                            bad_cnt_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                            if (!hdr_good) begin
                                bad_cnt_q <= bad_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcs_rx_descrambler_lock.sv
// Bench for pcs_rx_descrambler_lock: constant vectors, lock/loss sequences and random traffic
// compared against a bit-stream and header-rule model.
module tb_pcs_rx_descrambler_lock;

    localparam int W         = 64;
    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 64;
    localparam int BAD_LIMIT = 16;
    localparam int ERR_CNT_W = 8;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [W-1:0]         in_data = '0;
    logic [1:0]           in_header = '0;
    logic                 in_data_valid = 1'b0;
    logic                 bypass = 1'b0;
    logic [W-1:0]         out_data;
    logic [1:0]           out_header;
    logic                 out_data_valid;
    logic                 block_lock;
    logic                 slip;
    logic [ERR_CNT_W-1:0] bad_hdr_cnt;

    pcs_rx_descrambler_lock #(
        .PCS_DATA_WIDTH(W),
        .LOCK_CNT(LOCK_CNT),
        .WINDOW(WINDOW),
        .BAD_LIMIT(BAD_LIMIT),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_header(in_header),
        .in_data_valid(in_data_valid),
        .bypass(bypass),
        .out_data(out_data),
        .out_header(out_header),
        .out_data_valid(out_data_valid),
        .block_lock(block_lock),
        .slip(slip),
        .bad_hdr_cnt(bad_hdr_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int slips   = 0;

    // Reference model: received bit history plus header-rule counters.
    bit           hist[$];
    logic [W-1:0] m_data;
    logic [1:0]   m_hdr;
    logic         m_valid;
    logic         m_locked;
    logic         m_slip;
    int           m_good, m_win, m_bad, m_badtot, m_beats;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   hdr;
        logic         valid;
        logic         byp;
        logic [W-1:0] exp_data;
        logic         exp_valid;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_data = '0; m_hdr = '0; m_valid = 0; m_locked = 0; m_slip = 0;
        m_good = 0; m_win = 0; m_bad = 0; m_badtot = 0; m_beats = 0;
    endtask

    task automatic model_beat(input logic [W-1:0] d, input logic [1:0] h, input logic v,
                              input logic b);
        logic [W-1:0] od;
        bit t39, t58;
        bit good;
        m_slip = 0;
        m_hdr  = h;
        m_valid = v;
        if (!v) return;
        for (int i = 0; i < W; i++) begin
            t39 = (hist.size() >= 39) ? hist[hist.size() - 39] : 1'b0;
            t58 = (hist.size() >= 58) ? hist[hist.size() - 58] : 1'b0;
            od[i] = d[i] ^ t39 ^ t58;
            hist.push_back(d[i]);
            if (hist.size() > 64) void'(hist.pop_front());
        end
        m_data = b ? d : od;
        if (W == 64 || (m_beats % 2) == 0) begin
            good = (h == 2'b01) || (h == 2'b10);
            if (!good && m_badtot < ERR_MAX) m_badtot++;
            if (!m_locked) begin
                if (good) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; end
                end else begin
                    m_good = 0; m_slip = 1;
                end
            end else begin
                m_win++;
                if (!good) m_bad++;
                if (m_bad == BAD_LIMIT) begin
                    m_locked = 0; m_slip = 1; m_win = 0; m_bad = 0; m_good = 0;
                end else if (m_win == WINDOW) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end
        m_beats++;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic [1:0] h, input logic v,
                        input logic b);
        in_data = d; in_header = h; in_data_valid = v; bypass = b;
        @(posedge clk);
        #1;
        model_beat(d, h, v, b);
        if (slip) slips++;
        chk("out_data", out_data, m_data);
        chk("out_data_valid", out_data_valid, m_valid);
        if (m_valid) chk("out_header", out_header, m_hdr);
        chk("block_lock", block_lock, m_locked);
        chk("slip", slip, m_slip);
        chk("bad_hdr_cnt", bad_hdr_cnt, m_badtot);
    endtask

    task automatic do_reset();
        in_data_valid = 0; in_data = '0; in_header = '0; bypass = 0;
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 6; k++) begin
            beat(tbl[k].data, tbl[k].hdr, tbl[k].valid, tbl[k].byp);
            chk({tag, "_data"}, out_data, tbl[k].exp_data);
            chk({tag, "_valid"}, out_data_valid, tbl[k].exp_valid);
        end
    endtask

    task automatic good_beats(input int n);
        for (int i = 0; i < n; i++) beat({$urandom, $urandom}, 2'b01, 1'b1, 1'b0);
    endtask

    initial begin
        logic [63:0] rd;
        logic [1:0]  rh;
        int          lock_min;

        // A single scrambled 1 hits output bits 0, 39 and 58, all inside the same beat.
        tbl[0] = '{64'h0000_0000_0000_0001, 2'b01, 1'b1, 1'b0, 64'h0400_0080_0000_0001, 1'b1};
        tbl[1] = '{64'h0000_0000_0000_0000, 2'b01, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b0};
        tbl[3] = '{64'h8000_0000_0000_0000, 2'b10, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        tbl[4] = '{64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
        // Bit 63 seen during bypass must still land on bits 38 and 57 of the next beat.
        tbl[5] = '{64'h0000_0000_0000_0000, 2'b01, 1'b1, 1'b0, 64'h0200_0040_0000_0000, 1'b1};

        #2 rst = 0;
        #1;
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_valid", out_data_valid, 1'b0);
        chk("rst_out_header", out_header, 2'b00);
        chk("rst_block_lock", block_lock, 1'b0);
        chk("rst_slip", slip, 1'b0);
        chk("rst_bad_hdr_cnt", bad_hdr_cnt, 0);
        do_reset();

        run_table("tbl");

        // Lock acquisition.
        do_reset();
        slips = 0;
        good_beats(LOCK_CNT - 1);
        chk("t2_lock_before", block_lock, 1'b0);
        good_beats(1);
        chk("t2_lock_rise", block_lock, 1'b1);
        chk("t2_no_slip", slips, 0);
        chk("t2_bad_cnt", bad_hdr_cnt, 0);

        // 16 bad headers within one window drop lock with one slip.
        slips = 0;
        for (int i = 0; i < WINDOW; i++) begin
            beat({$urandom, $urandom}, (i % 4 == 0) ? 2'b11 : 2'b10, 1'b1, 1'b0);
            if (i == 59) chk("t3_lock_before", block_lock, 1'b1);
            if (i == 60) chk("t3_lock_fall", block_lock, 1'b0);
        end
        chk("t3_one_slip", slips, 1);
        chk("t3_bad_cnt", bad_hdr_cnt, 16);

        // 15 bad headers in each of two windows keep lock.
        do_reset();
        good_beats(LOCK_CNT);
        slips = 0;
        lock_min = 1;
        for (int i = 0; i < 2 * WINDOW; i++) begin
            beat({$urandom, $urandom}, ((i % 64) % 4 == 0 && (i % 64) < 60) ? 2'b00 : 2'b01,
                 1'b1, 1'b0);
            if (!block_lock) lock_min = 0;
        end
        chk("t4_lock_held", lock_min, 1);
        chk("t4_no_slip", slips, 0);
        chk("t4_bad_cnt", bad_hdr_cnt, 30);

        // 16th bad header on the window's last header: loss of lock wins.
        for (int i = 0; i < WINDOW; i++) begin
            beat({$urandom, $urandom}, (i < 15 || i == WINDOW - 1) ? 2'b11 : 2'b01, 1'b1, 1'b0);
            if (i == WINDOW - 2) chk("t4b_lock_before", block_lock, 1'b1);
        end
        chk("t4b_lock_lost", block_lock, 1'b0);
        chk("t4b_slip", slip, 1'b1);

        // Random traffic with segments of heavy header errors.
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            rd = {$urandom, $urandom};
            if (((i / 200) % 3) == 2) rh = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 1) * 3)
                                                                        : 2'($urandom_range(1, 2));
            else rh = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 1) * 3)
                                                   : 2'($urandom_range(1, 2));
            beat(rd, rh, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
        end

        // Error counter saturation.
        for (int i = 0; i < ERR_MAX + 20; i++) beat({$urandom, $urandom}, 2'b00, 1'b1, 1'b0);
        chk("sat_bad_cnt", bad_hdr_cnt, ERR_MAX);

        // Asynchronous reset while locked, mid-beat.
        good_beats(LOCK_CNT);
        chk("t6_locked", block_lock, 1'b1);
        in_data = 64'h1234_5678_9ABC_DEF0; in_header = 2'b01; in_data_valid = 1; bypass = 0;
        #2 rst = 0;
        #1;
        chk("t6_async_data", out_data, 64'h0);
        chk("t6_async_valid", out_data_valid, 1'b0);
        chk("t6_async_header", out_header, 2'b00);
        chk("t6_async_lock", block_lock, 1'b0);
        chk("t6_async_bad_cnt", bad_hdr_cnt, 0);
        do_reset();
        run_table("t6_tbl");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
